n64_vdemux: RTL



---
 rtl/n64_vdemux_pkg.sv | 21 ++
 rtl/n64_vdemux_if.sv | 24 ++
 rtl/n64_vdemux_vinfo.sv | 62 ++++++
 rtl/n64_vdemux.sv | 136 +++++++++++++
 4 files changed

// File: rtl/n64_vdemux_pkg.sv
// Shared constants and lock-FSM encoding for the N64 video front end.
package n64adv_vparams;

  localparam int color_width_i = 7;
  localparam int vdata_width_i = 4 + 3 * color_width_i;

  localparam int SYNC_LSB = 3 * color_width_i;
  localparam int R_LSB    = 2 * color_width_i;
  localparam int G_LSB    = color_width_i;
  localparam int B_LSB    = 0;

  localparam int LOCK_CNT  = 8;
  localparam int PAL_LINES = 288;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKING  = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_t;

endpackage

// File: rtl/n64_vdemux_if.sv
// Serial video bus in, assembled {sync,R,G,B} words and status out.
interface n64_vdemux_if;
  import n64adv_vparams::*;

  logic                     nDSYNC;
  logic [color_width_i-1:0] D_i;
  logic                     vdata_valid_o;
  logic [vdata_width_i-1:0] vdata_o;
  logic                     lock_o;
  logic                     phase_err_o;
  logic                     palmode_o;
  logic                     interlaced_o;

  modport master (
    output nDSYNC, D_i,
    input  vdata_valid_o, vdata_o, lock_o, phase_err_o, palmode_o, interlaced_o
  );

  modport slave (
    input  nDSYNC, D_i,
    output vdata_valid_o, vdata_o, lock_o, phase_err_o, palmode_o, interlaced_o
  );

endinterface

// File: rtl/n64_vdemux_vinfo.sv
// Line counter plus PAL/interlace detection, driven by the sync nibble of each valid word.
module n64_vinfo_detect
  import n64adv_vparams::*;
(
  input  logic       VCLK,
  input  logic       RST,
  input  logic       i_lock,
  input  logic       i_valid,
  input  logic [3:0] i_sync,
  output logic       o_palmode,
  output logic       o_interlaced
);

  logic       r_prev_v;
  logic       r_prev_h;
  logic [9:0] r_lines;
  logic [9:0] r_last;
  logic       r_pal;
  logic       r_intl;
  logic       w_hfall;
  logic       w_vfall;
  logic [9:0] w_lines_inc;
  logic       w_unused;

  assign w_unused = ^{i_sync[2], i_sync[0]};

  assign w_hfall = r_prev_h & ~i_sync[1];
  assign w_vfall = r_prev_v & ~i_sync[3];
  // HSYNC fall in the same word as VSYNC fall is counted before latching.
  assign w_lines_inc = (w_hfall && (r_lines != '1)) ? r_lines + 10'd1 : r_lines;

  always_ff @(posedge VCLK) begin
    if (RST) begin
      r_prev_v <= 1'b0;
      r_prev_h <= 1'b0;
      r_lines  <= '0;
      r_last   <= '0;
      r_pal    <= 1'b0;
      r_intl   <= 1'b0;
    end else if (!i_lock) begin
      r_prev_v <= 1'b0;
      r_prev_h <= 1'b0;
      r_lines  <= '0;
      r_last   <= '0;
    end else if (i_valid) begin
      r_prev_v <= i_sync[3];
      r_prev_h <= i_sync[1];
      if (w_vfall) begin
        r_last  <= w_lines_inc;
        r_pal   <= (w_lines_inc > 10'(PAL_LINES));
        r_intl  <= (w_lines_inc != r_last);
        r_lines <= '0;
      end else begin
        r_lines <= w_lines_inc;
      end
    end
  end

  assign o_palmode    = r_pal;
  assign o_interlaced = r_intl;

endmodule

// File: rtl/n64_vdemux.sv
// N64 serial video demux: phase tracking, word assembly and bus lock FSM.
module n64_vdemux #(
  parameter int LOCK_CNT = n64adv_vparams::LOCK_CNT
) (
  input logic         VCLK,
  input logic         RST,
  n64_vdemux_if.slave bus
);

  localparam int CW = n64adv_vparams::color_width_i;
  localparam int VW = n64adv_vparams::vdata_width_i;
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);

  n64adv_vparams::lock_state_t r_state;

  logic [1:0]    r_ph;
  logic          r_wvalid;
  logic [3:0]    r_s;
  logic [CW-1:0] r_r;
  logic [CW-1:0] r_g;
  logic [CW-1:0] r_b;
  logic [GW-1:0] r_good;
  logic          r_miss;
  logic          r_valid;
  logic          r_perr;
  logic [VW-1:0] r_vdata;

  logic w_strobe;
  logic w_good;
  logic w_bad;
  logic w_lock;
  logic w_palmode;
  logic w_interlaced;

  assign w_strobe = ~bus.nDSYNC;
  assign w_good   = w_strobe && (r_ph == 2'd0);
  // Bad = early strobe (ph 1..3) or missing strobe at ph 0.
  assign w_bad    = w_strobe ? (r_ph != 2'd0) : (r_ph == 2'd0);
  assign w_lock   = (r_state == n64adv_vparams::ST_LOCKED);

  always_ff @(posedge VCLK) begin
    if (RST) begin
      r_state  <= n64adv_vparams::ST_UNLOCKED;
      r_ph     <= '0;
      r_wvalid <= 1'b0;
      r_s      <= '0;
      r_r      <= '0;
      r_g      <= '0;
      r_b      <= '0;
      r_good   <= '0;
      r_miss   <= 1'b0;
      r_valid  <= 1'b0;
      r_perr   <= 1'b0;
      r_vdata  <= '0;
    end else begin
      r_valid <= 1'b0;
      r_perr  <= 1'b0;

      if (w_strobe) begin
        r_ph     <= 2'd1;
        r_s      <= bus.D_i[3:0];
        r_wvalid <= 1'b1;
      end else begin
        r_ph <= r_ph + 2'd1;
        case (r_ph)
          2'd1:    r_r <= bus.D_i;
          2'd2:    r_g <= bus.D_i;
          2'd3:    r_b <= bus.D_i;
          default: r_wvalid <= 1'b0;
        endcase
      end

      // The word assembled over the last period is released on the strobe that closes it.
      if (w_lock && w_good && r_wvalid) begin
        r_vdata <= {r_s, r_r, r_g, r_b};
        r_valid <= 1'b1;
      end

      case (r_state)
        n64adv_vparams::ST_UNLOCKED: begin
          if (w_strobe) begin
            r_state <= n64adv_vparams::ST_LOCKING;
            r_good  <= '0;
            r_miss  <= 1'b0;
          end
        end
        n64adv_vparams::ST_LOCKING: begin
          if (w_good) begin
            if (r_good == GOOD_LAST) begin
              r_state <= n64adv_vparams::ST_LOCKED;
              r_good  <= '0;
              r_miss  <= 1'b0;
            end else begin
              r_good <= r_good + 1'b1;
            end
          end else if (w_bad) begin
            r_good <= '0;
          end
        end
        n64adv_vparams::ST_LOCKED: begin
          if (w_bad) begin
            r_perr <= 1'b1;
            if (r_miss) begin
              r_state <= n64adv_vparams::ST_UNLOCKED;
              r_miss  <= 1'b0;
            end else begin
              r_miss <= 1'b1;
            end
          end else if (w_good) begin
            r_miss <= 1'b0;
          end
        end
        default: r_state <= n64adv_vparams::ST_UNLOCKED;
      endcase
    end
  end

  n64_vinfo_detect u_vinfo (
    .VCLK         (VCLK),
    .RST          (RST),
    .i_lock       (w_lock),
    .i_valid      (r_valid),
    .i_sync       (r_vdata[n64adv_vparams::SYNC_LSB +: 4]),
    .o_palmode    (w_palmode),
    .o_interlaced (w_interlaced)
  );

  assign bus.vdata_valid_o = r_valid;
  assign bus.vdata_o       = r_vdata;
  assign bus.lock_o        = w_lock;
  assign bus.phase_err_o   = r_perr;
  assign bus.palmode_o     = w_palmode;
  assign bus.interlaced_o  = w_interlaced;

endmodule
